program_loader: RTL and testbench

Boot-time loader that sits directly upstream of the multi-cycle CPU's unified word memory. It receives a length-prefixed program image as a byte stream over a valid/ready handshake and packs bytes into 32-bit big-endian words. It writes those words into memory through a single write port, then releases the CPU by asserting `cpu_run`. Until then the CPU is held idle, so it never fetches a partially loaded image.

---
 rtl/loader_pkg.sv | 38 +++
 rtl/program_loader_word_packer.sv | 43 ++++
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   loader_state_t : loader FSM state encoding
//   LEN_BYTES      : bytes in the big-endian length header
//   BYTES_PER_WORD : payload bytes packed into each memory word
//   header_ok()    : validates the header word count against the memory window
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the S_CHK state.
package loader_pkg;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } loader_state_t;

  // Non-zero, within MAX_WORDS, and the image must not run past the top of memory.
  function automatic logic header_ok(input logic [LEN_W-1:0] n,
                                     input int unsigned      base,
                                     input int unsigned      addr_w,
                                     input int unsigned      max_words);
    longint unsigned limit;
    longint unsigned last;
    limit = 64'(1) << addr_w;
    last  = 64'(base) + 64'(n);
    return (n != '0) && (32'(n) <= max_words) && (last <= limit);
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// word_packer: collects bytes MSB-first into 32-bit words.
//   clk, rst_n  : clock, async active-low reset
//   clear       : drop any partial word
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word_valid  : combinational; the current byte completes a word
//   word_data   : combinational; completed word (valid with word_valid)
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [1:0]         cnt;
  logic [SHIFT_W-1:0] shift;

  // The fourth byte is merged combinationally so the top can register the word on that same edge.
  assign word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word_data  = {shift, byte_data};

  // Byte counter and shift register of the first three bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (byte_valid) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[SHIFT_W-BYTE_W-1:0], byte_data};
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte image, packs it into
// big-endian words, writes them to CPU memory and then releases the CPU.
//   clk, rst_n          : clock, async active-low reset
//   in_data/valid/ready : byte stream handshake
//   restart             : pulse in DONE/ERROR to begin another load
//   mem_we/addr/wdata   : memory write port, one strobe per word
//   cpu_run             : CPU may execute
//   busy                : load in progress
//   error               : load rejected (sticky until restart/reset)
//   words_loaded        : words written in this load
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_t     state, state_nxt;
  logic              accept;
  logic              restart_go;
  logic              pack_en;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              last_word;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  hdr_n;
  logic              hdr_ok;
  logic [CNT_W-1:0]  n_words;
  logic              in_ready_d;
  logic              error_d;
  logic              cpu_run_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = in_valid && in_ready;
  assign restart_go = restart && ((state == S_DONE) || (state == S_ERROR));
  assign pack_en    = accept && (state == S_DATA);
  assign hdr_n      = {len_hi, in_data};
  assign hdr_ok     = header_ok(hdr_n, BASE_ADDR, ADDR_W, MAX_WORDS);
  assign last_word  = word_valid && (CNT_W'(words_loaded + CNT_W'(1)) == n_words);

  word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart_go),
    .byte_valid (pack_en),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LEN_HI;
    else        state <= state_nxt;
  end

  // Next state and next values of the registered status outputs.
  always_comb begin
    state_nxt  = state;
    in_ready_d = 1'b0;
    error_d    = 1'b0;
    cpu_run_d  = 1'b0;
    case (state)
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: if (accept) state_nxt = hdr_ok ? S_DATA : S_ERROR;
      S_DATA: begin
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
`endif
      S_DONE:  if (restart) state_nxt = S_LEN_HI;
      S_ERROR: if (restart) state_nxt = S_LEN_HI;
      default: state_nxt = S_LEN_HI;
    endcase

    case (state_nxt)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready_d = 1'b1;
`endif
      default:                    in_ready_d = 1'b0;
    endcase

    error_d   = (state_nxt == S_ERROR);
    // Run is held back one cycle so it follows the final memory write.
    cpu_run_d = (state == S_DONE) && (state_nxt == S_DONE);
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      busy     <= 1'b1;
      cpu_run  <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= in_ready_d;
      busy     <= !(error_d || cpu_run_d);
      cpu_run  <= cpu_run_d;
      error    <= error_d;
    end
  end

  // Header capture, memory write port and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi       <= '0;
      n_words      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= word_valid;
      if (accept && (state == S_LEN_HI)) len_hi <= in_data;
      if (accept && (state == S_LEN_LO)) n_words <= CNT_W'(hdr_n);
      if (word_valid) begin
        mem_addr     <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
        mem_wdata    <= word_data;
        words_loaded <= words_loaded + CNT_W'(1);
      end
      if (restart_go) begin
        mem_addr     <= ADDR_W'(BASE_ADDR);
        words_loaded <= '0;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes, restarted at each header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             csum <= '0;
    else if (accept && (state == S_LEN_LO)) csum <= '0;
    else if (pack_en)                       csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them on every mem_we.
module tb_program_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int total = 0;
  int bad   = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0] img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Write monitor.
  always @(negedge clk) begin : mon
    logic [ADDR_W+31:0] e;
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h want none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        chk("we_data", mem_wdata, e[31:0]);
      end
    end
  end

  // Drives one byte starting at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    in_data  = b;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      acc = in_ready;
      @(negedge clk);
      n++;
      if (!acc && n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no ready want ready for byte 0x%0h", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Sends img (header + payload), plus the checksum byte when that feature is built.
  task automatic load_image(input int gap, input bit bad_csum);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      if (i >= 2) cs = cs ^ img[i];
      send_byte(img[i]);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    repeat (gap) @(negedge clk);
    send_byte(cs ^ {7'd0, bad_csum});
`else
    if (bad_csum) cs = ~cs;
`endif
  endtask

  // Called in the cycle after the final byte.
  task automatic check_done(input int n);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    chk("last_we", 32'(mem_we), 32'd1);
`endif
    chk("run_early", 32'(cpu_run), 32'd0);
    chk("busy_t1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("run_rise", 32'(cpu_run), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("err_done", 32'(error), 32'd0);
    chk("rdy_done", 32'(in_ready), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'(n));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_run", 32'(cpu_run), 32'd0);
    chk("rs_err", 32'(error), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_rdy", 32'(in_ready), 32'd1);
    chk("rs_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic check_reject();
    chk("rej_err", 32'(error), 32'd1);
    chk("rej_rdy", 32'(in_ready), 32'd0);
    chk("rej_busy", 32'(busy), 32'd0);
    chk("rej_run", 32'(cpu_run), 32'd0);
    // Bytes offered while not ready must be ignored.
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("rej_rdy_hold", 32'(in_ready), 32'd0);
    chk("rej_run_hold", 32'(cpu_run), 32'd0);
    chk("rej_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back N=2 image.
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    push_word(10'd0, 32'h12345678);
    push_word(10'd1, 32'h9ABCDEF0);
    load_image(0, 1'b0);
    check_done(2);

    // Same image with a one-cycle bubble between bytes.
    do_restart();
    push_word(10'd0, 32'h12345678);
    push_word(10'd1, 32'h9ABCDEF0);
    load_image(1, 1'b0);
    check_done(2);

    // Zero-length header.
    do_restart();
    send_byte(8'h00);
    send_byte(8'h00);
    check_reject();

    // 1025 words exceeds the memory.
    do_restart();
    send_byte(8'h04);
    send_byte(8'h01);
    check_reject();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_restart();
    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    push_word(10'd0, 32'h01020304);
    load_image(0, 1'b0);
    check_done(1);

    do_restart();
    push_word(10'd0, 32'h01020304);
    load_image(0, 1'b1);
    chk("csum_err", 32'(error), 32'd1);
    chk("csum_run", 32'(cpu_run), 32'd0);
    chk("csum_words", 32'(words_loaded), 32'd1);
    @(negedge clk);
    chk("csum_run_hold", 32'(cpu_run), 32'd0);
    chk("csum_sb", 32'(exp_q.size()), 32'd0);
`endif

    // Reset after six payload bytes, then a full reload.
    do_restart();
    push_word(10'd0, 32'h12345678);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    send_byte(8'hBC);
    chk("mid_words", 32'(words_loaded), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_sb", 32'(exp_q.size()), 32'd0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    push_word(10'd0, 32'h12345678);
    push_word(10'd1, 32'h9ABCDEF0);
    load_image(0, 1'b0);
    check_done(2);

    // Restart from DONE and load a fresh single-word image.
    do_restart();
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_word(10'd0, 32'hAABBCCDD);
    load_image(0, 1'b0);
    check_done(1);

    repeat (3) @(negedge clk);
    chk("final_sb", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
